strobe_sequencer: RTL and testbench
===================================

// Module: strobe_sequencer
// PURPOSE
//  Upstream driver for a 74S138-style 3-to-8 strobe decoder. Accepts one device-select request at a time.
//  Presents the 3-bit select {C,B,A} with the decoder disabled, then enables it for a timed strobe, then holds
//  the select after disable. Guarantees glitch-free decoded Y outputs; all decoder-facing outputs are registered.
// PARAMETERS
//  SETUP_CYC    1   cycles select is stable before enable; 0 treated as 1
//  STROBE_CYC   2   cycles decoder is enabled (minimum strobe); 0 treated as 1
//  HOLD_CYC     1   cycles select is held after disable; 0 treated as 1
//  CNT_W        4   phase counter width; every *_CYC must be < 2**CNT_W
//  TIMEOUT_CYC  15  max extra strobe cycles waiting for dev_ack (only with STROBE_SEQ_ACK_EN)
// PORTS
//  clk        in   1  sole clock, rising edge
//  reset      in   1  synchronous, active-high
//  req_valid  in   1  request present
//  req_sel    in   3  device select {C,B,A}; sampled on accept
//  req_ready  out  1  high in IDLE and not reset; accept = req_valid & req_ready at clk edge
//  dev_ack    in   1  device acknowledge (used only with STROBE_SEQ_ACK_EN)
//  sel_a      out  1  decoder A (req_sel[0])
//  sel_b      out  1  decoder B (req_sel[1])
//  sel_c      out  1  decoder C (req_sel[2])
//  g1         out  1  decoder G1, active-high enable
//  g2a_n      out  1  decoder G2A, active-low enable
//  g2b_n      out  1  decoder G2B, active-low enable
//  busy       out  1  high in any state other than IDLE
//  done       out  1  one-cycle pulse on the cycle the sequencer returns to IDLE
//  err        out  1  one-cycle pulse on ack timeout; tied 0 without STROBE_SEQ_ACK_EN
// BEHAVIOUR
//  - Reset values: sel_a/b/c=0, g1=0, g2a_n=1, g2b_n=1, busy=0, done=0, err=0, state=IDLE, counter=0.
//  - Reset asserted mid-sequence: state returns to IDLE at that edge. Enables drop (g1=0, g2a_n=g2b_n=1) at that
//    same edge. No done pulse. req_ready is low while reset is high.
//  - States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. Counter is loaded with N-1 on phase entry.
//    The phase exits when the counter reaches 0.
//  - IDLE: on accept, latch req_sel into sel_c/b/a and go to SETUP. While idle, sel_* keep their last value.
//  - SETUP: g1=1, g2a_n=1, g2b_n=1; decoder is disabled and all Y are high.
//  - STROBE: g1=1, g2a_n=0, g2b_n=0; exactly one Y is low.
//  - HOLD: g1=1, g2a_n=1, g2b_n=1; sel_* are unchanged.
//  - Latency: from the accept edge, SETUP_CYC+STROBE_CYC+HOLD_CYC cycles, then done=1 for one cycle in IDLE.
//    With default parameters this is 4 cycles.
//  - Back-to-back: req_ready is high in the done cycle, so a new request may be accepted there with no bubble.
//  - sel_* never change while g2a_n=0. Enables change only on cycles where sel_* are stable.
//  - req_valid during busy is ignored; the requester must hold it until req_ready.
// CONFIGURATION
//  STROBE_SEQ_ACK_EN defined:
//    - After STROBE_CYC cycles, STROBE persists until dev_ack=1 is sampled; dev_ack is sampled from the last
//      minimum STROBE cycle onward.
//    - If dev_ack does not arrive within TIMEOUT_CYC extra cycles: err pulses one cycle, the sequencer moves to
//      HOLD, and the sequence ends normally with done.
//    - dev_ack=1 on the last minimum STROBE cycle gives zero extra cycles.
//  STROBE_SEQ_ACK_EN not defined: dev_ack ignored; err constant 0; STROBE lasts exactly STROBE_CYC cycles.
// STRUCTURE
//  - Package strobe_seq_pkg holds:
//    - state encoding constants ST_IDLE=2'd0, ST_SETUP=2'd1, ST_STROBE=2'd2, ST_HOLD=2'd3;
//    - the enable-pattern constants ENA_OFF={g1,g2a_n,g2b_n}=3'b011, ENA_SETUP=3'b111, ENA_STROBE=3'b100.
//  - One sub-module, strobe_seq_timer: loadable CNT_W down-counter (load, dec, zero flag).
//    The timeout counter reuses a second instance.
//  - Top level: FSM, select register, output registers.
// TESTING
//  - Reset: hold reset 2 cycles -> g1=0, g2a_n=g2b_n=1, sel=000, busy=0, req_ready=0; release -> req_ready=1.
//  - Single request, defaults, req_sel=3'b101:
//    - sel=101 one cycle after accept, with ENA_SETUP for 1 cycle;
//    - then ENA_STROBE for 2 cycles, during which the decoder has Y5 low only;
//    - then ENA_SETUP for 1 cycle (HOLD), then done=1 and ENA_OFF.
//  - Back-to-back: req_sel 3'b000 then 3'b111 with req_valid held -> second accepted in the done cycle.
//    sel switches only while the enables are off.
//  - Reset mid-STROBE (cycle 2 of request) -> next edge IDLE, ENA_OFF, no done pulse; next request completes normally.
//  - Parameters SETUP_CYC=0, STROBE_CYC=3, HOLD_CYC=2 -> phases last 1/3/2 cycles; done exactly 6 cycles after accept.
//  - STROBE_SEQ_ACK_EN:
//    - dev_ack on extra cycle 3 -> STROBE lasts STROBE_CYC+3 cycles, err=0.
//    - dev_ack never -> err pulse after TIMEOUT_CYC=15 extra cycles, then HOLD and done.

Source files
------------

// File: rtl/strobe_seq_pkg.sv
// Shared encodings for the strobe sequencer: FSM states and decoder enable patterns.
// Enable patterns are packed as {g1, g2a_n, g2b_n}.
package strobe_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [2:0] ENA_OFF    = 3'b011;
  localparam logic [2:0] ENA_SETUP  = 3'b111;
  localparam logic [2:0] ENA_STROBE = 3'b100;

  // Phase lengths of zero are stretched to one cycle.
  function automatic int unsigned min1(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/strobe_seq_timer.sv
// Loadable down-counter used for phase timing and for the ack timeout.
// Load has priority over decrement; the count saturates at zero.
module strobe_seq_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/strobe_sequencer.sv
// Drives a 3-to-8 strobe decoder: select setup, timed enable strobe, select hold.
// Define STROBE_SEQ_ACK_EN to stretch the strobe until dev_ack, with a timeout that pulses err.
module strobe_sequencer
  import strobe_seq_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 2,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_sel,
  output logic       req_ready,
  input  logic       dev_ack,
  output logic       sel_a,
  output logic       sel_b,
  output logic       sel_c,
  output logic       g1,
  output logic       g2a_n,
  output logic       g2b_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(min1(SETUP_CYC) - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(min1(STROBE_CYC) - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(min1(HOLD_CYC) - 1);

  state_e           state_q;
  state_e           state_d;
  logic [2:0]       sel_q;
  logic [2:0]       sel_d;
  logic [2:0]       ena_q;
  logic [2:0]       ena_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic             err_q;
  logic             err_d;

  logic             accept_c;
  logic             ph_load;
  logic [CNT_W-1:0] ph_val;
  logic             ph_dec;
  logic             ph_zero_c;
  logic             to_load;
  logic             to_dec;
  logic             timeout_c;

  assign req_ready = ~reset & (state_q == ST_IDLE);
  assign accept_c  = req_valid & req_ready;

  strobe_seq_timer #(.CNT_W(CNT_W)) u_ph_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .zero_c   (ph_zero_c)
  );

`ifdef STROBE_SEQ_ACK_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC);

  logic to_zero_c;

  // Counts the extra strobe cycles spent waiting for dev_ack.
  strobe_seq_timer #(.CNT_W(CNT_W)) u_to_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (to_load),
    .load_val (TIMEOUT_LD),
    .dec      (to_dec),
    .zero_c   (to_zero_c)
  );
`else
  logic unused_cfg;
  assign unused_cfg = dev_ack | (TIMEOUT_CYC != 0) | to_load | to_dec;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and timer control.
  always_comb begin
    state_d   = state_q;
    ph_load   = 1'b0;
    ph_val    = '0;
    ph_dec    = 1'b0;
    to_load   = 1'b0;
    to_dec    = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_SETUP;
          ph_load = 1'b1;
          ph_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (ph_zero_c) begin
          state_d = ST_STROBE;
          ph_load = 1'b1;
          ph_val  = STROBE_LD;
          to_load = 1'b1;
        end else begin
          ph_dec = 1'b1;
        end
      end
      ST_STROBE: begin
        if (!ph_zero_c) begin
          ph_dec = 1'b1;
        end else begin
`ifdef STROBE_SEQ_ACK_EN
          if (dev_ack) begin
            state_d = ST_HOLD;
            ph_load = 1'b1;
            ph_val  = HOLD_LD;
          end else if (to_zero_c) begin
            state_d   = ST_HOLD;
            ph_load   = 1'b1;
            ph_val    = HOLD_LD;
            timeout_c = 1'b1;
          end else begin
            to_dec = 1'b1;
          end
`else
          state_d = ST_HOLD;
          ph_load = 1'b1;
          ph_val  = HOLD_LD;
`endif
        end
      end
      ST_HOLD: begin
        if (ph_zero_c) begin
          state_d = ST_IDLE;
        end else begin
          ph_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the next cycle, decoded from the next state.
  always_comb begin
    ena_d  = ENA_OFF;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_HOLD) && (state_d == ST_IDLE);
    err_d  = timeout_c;
    sel_d  = accept_c ? req_sel : sel_q;
    case (state_d)
      ST_SETUP,
      ST_HOLD:   ena_d = ENA_SETUP;
      ST_STROBE: ena_d = ENA_STROBE;
      default:   ena_d = ENA_OFF;
    endcase
  end

  // Decoder-facing and status output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q  <= 3'b000;
      ena_q  <= ENA_OFF;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      ena_q  <= ena_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign {sel_c, sel_b, sel_a} = sel_q;
  assign {g1, g2a_n, g2b_n}    = ena_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign err                   = err_q;

endmodule

// File: tb/tb_strobe_sequencer.sv
// Scoreboard bench for strobe_sequencer: default-parameter and 0/3/2-parameter instances.
// Ack/timeout scenarios run when STROBE_SEQ_ACK_EN is defined.
module tb_strobe_sequencer;

  localparam logic [2:0] E_OFF = 3'b011;
  localparam logic [2:0] E_SET = 3'b111;
  localparam logic [2:0] E_STB = 3'b100;

  typedef struct {
    logic [2:0]  sel;
    int unsigned n_set;
    int unsigned n_str;
    int unsigned n_hold;
    int unsigned n_err;
  } exp_t;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       req_valid = 1'b0;
  logic       dev_ack   = 1'b1;
  logic [2:0] req_sel   = 3'b000;
  logic       dut_idx   = 1'b0;

  logic [1:0] rv_w, ready_w, sa_w, sb_w, sc_w, g1_w, g2a_w, g2b_w, busy_w, done_w, err_w;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  assign rv_w = {req_valid & dut_idx, req_valid & ~dut_idx};

  strobe_sequencer u_dut0 (
    .clk(clk), .reset(reset), .req_valid(rv_w[0]), .req_sel(req_sel), .req_ready(ready_w[0]),
    .dev_ack(dev_ack), .sel_a(sa_w[0]), .sel_b(sb_w[0]), .sel_c(sc_w[0]), .g1(g1_w[0]),
    .g2a_n(g2a_w[0]), .g2b_n(g2b_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
  );

  strobe_sequencer #(.SETUP_CYC(0), .STROBE_CYC(3), .HOLD_CYC(2)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(rv_w[1]), .req_sel(req_sel), .req_ready(ready_w[1]),
    .dev_ack(dev_ack), .sel_a(sa_w[1]), .sel_b(sb_w[1]), .sel_c(sc_w[1]), .g1(g1_w[1]),
    .g2a_n(g2a_w[1]), .g2b_n(g2b_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
  );

  logic [2:0] m_sel, m_ena;
  logic       m_busy, m_done, m_err, m_ready;
  assign m_sel   = {sc_w[dut_idx], sb_w[dut_idx], sa_w[dut_idx]};
  assign m_ena   = {g1_w[dut_idx], g2a_w[dut_idx], g2b_w[dut_idx]};
  assign m_busy  = busy_w[dut_idx];
  assign m_done  = done_w[dut_idx];
  assign m_err   = err_w[dut_idx];
  assign m_ready = ready_w[dut_idx];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] s, input int unsigned a, input int unsigned b,
                              input int unsigned c, input int unsigned e);
    exp_t r;
    r.sel = s; r.n_set = a; r.n_str = b; r.n_hold = c; r.n_err = e;
    return r;
  endfunction

  // Monitor: measures each transaction's phases on the falling edge and scores it at done.
  int unsigned cyc = 0, acc_cyc = 0, done_cyc = 0;
  int unsigned n_set = 0, n_str = 0, n_hold = 0, n_err = 0;
  bit          in_txn = 1'b0;
  logic [2:0]  prev_sel = 3'b000;
  logic        prev_g2a = 1'b1;
  logic        prev_rst = 1'b1;

  always @(negedge clk) begin
    logic [7:0] y;
    logic [7:0] y_exp;
    exp_t       cur;
    cyc++;
    for (int i = 0; i < 8; i++)
      y[i] = ~(m_ena[2] & ~m_ena[1] & ~m_ena[0] & (m_sel == 3'(i)));
    if (!prev_rst && (m_sel != prev_sel))
      check("sel_change_while_enabled", {prev_g2a, m_ena[1]}, 3);
    if (reset) begin
      in_txn = 1'b0;
      exp_q.delete();
    end else begin
      if (in_txn) begin
        if (m_ena == E_STB) begin
          n_str++;
          if (exp_q.size() > 0) begin
            y_exp = ~(8'h01 << exp_q[0].sel);
            check("strobe_y", y, y_exp);
          end
        end else if (m_ena == E_SET) begin
          if (n_str == 0) n_set++; else n_hold++;
        end
        if (m_err) n_err++;
        if (m_done) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 0, 1);
          end else begin
            cur = exp_q.pop_front();
            check("latency", cyc - acc_cyc - 1, cur.n_set + cur.n_str + cur.n_hold);
            check("setup_len", n_set, cur.n_set);
            check("strobe_len", n_str, cur.n_str);
            check("hold_len", n_hold, cur.n_hold);
            check("err_pulses", n_err, cur.n_err);
            check("done_ena", m_ena, E_OFF);
            check("done_busy", m_busy, 0);
          end
          in_txn   = 1'b0;
          done_cyc = cyc;
        end
      end else if (m_done) begin
        check("spurious_done", 1, 0);
      end
      if (req_valid && m_ready) begin
        in_txn = 1'b1; acc_cyc = cyc;
        n_set = 0; n_str = 0; n_hold = 0; n_err = 0;
      end
    end
    prev_sel = m_sel;
    prev_g2a = m_ena[1];
    prev_rst = reset;
  end

  task automatic send(input logic [2:0] s, input exp_t e);
    int n;
    n = 0;
    exp_q.push_back(e);
    req_sel   = s;
    req_valid = 1'b1;
    while (!m_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_txn) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || in_txn) check("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ena", m_ena, E_OFF);
    check("rst_sel", m_sel, 0);
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_err", m_err, 0);
    check("rst_ready", m_ready, 0);
    reset = 1'b0;
    #1;
    check("rel_ready", m_ready, 1);
    @(posedge clk); #1;

    send(3'b101, mk(3'b101, 1, 2, 1, 0));
    wait_idle();

    send(3'b000, mk(3'b000, 1, 2, 1, 0));
    send(3'b111, mk(3'b111, 1, 2, 1, 0));
    check("b2b_no_bubble", acc_cyc, done_cyc);
    wait_idle();

    send(3'b010, mk(3'b010, 1, 2, 1, 0));
    repeat (2) @(posedge clk);
    #1;
    check("mid_strobe_ena", m_ena, E_STB);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ena", m_ena, E_OFF);
    check("abort_busy", m_busy, 0);
    check("abort_done", m_done, 0);
    check("abort_ready", m_ready, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", m_done, 0);
    end
    send(3'b110, mk(3'b110, 1, 2, 1, 0));
    wait_idle();

    dut_idx = 1'b1;
    #1;
    send(3'b011, mk(3'b011, 1, 3, 2, 0));
    send(3'b100, mk(3'b100, 1, 3, 2, 0));
    wait_idle();
    dut_idx = 1'b0;
    #1;

`ifdef STROBE_SEQ_ACK_EN
    dev_ack = 1'b0;
    send(3'b001, mk(3'b001, 1, 5, 1, 0));
    repeat (5) @(posedge clk);
    #1;
    dev_ack = 1'b1;
    @(posedge clk); #1;
    dev_ack = 1'b0;
    wait_idle();

    send(3'b110, mk(3'b110, 1, 17, 1, 1));
    wait_idle();
    dev_ack = 1'b1;
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
